fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter and fetch-sequencing stage that drives `prog_ctr` into the instruction ROM, which returns the 9-bit `mach_code` combinationally in the same cycle. It owns the run/idle/done lifecycle of a program: start, sequential fetch, relative and absolute jumps, stalls and halt. It also keeps a saturating cycle counter for milestone performance reporting. Branch and jump requests arrive from the decode/execute logic that consumes `mach_code`.

## Interface
- D, 12: program-counter width; must match the instruction ROM address width.
- OW, 8: width of the signed relative-jump offset.
- CW, 16: cycle-counter width.

- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE state.
- start  input  1  one-cycle pulse; begins execution at `start_addr`.
- start_addr  input  D  first instruction address, sampled on the accepted `start`.
- stall  input  1  hold `prog_ctr` this cycle.
- halt  input  1  current instruction is the program's last; stop fetching.
- abs_jump_en  input  1  load `abs_target` next cycle.
- abs_target  input  D  absolute jump destination.
- rel_jump_en  input  1  add `rel_offset` to the current PC next cycle.
- rel_offset  input  OW  two's-complement offset relative to the current `prog_ctr`.
- prog_ctr  output  D  registered fetch address to the instruction ROM.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- cycle_count  output  CW  count of RUN cycles since the last accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `prog_ctr` is 0.
  - `start` loads `start_addr`, clears `cycle_count` and enters RUN.
- RUN: the next PC is chosen by strict priority:
  1. `halt`: PC holds and the state goes to DONE.
  2. `stall`: PC holds.
  3. `abs_jump_en`: PC becomes `abs_target`.
  4. `rel_jump_en`: PC becomes `prog_ctr` + sign-extended `rel_offset`, modulo 2^D.
  5. Otherwise: PC becomes `prog_ctr` + 1, modulo 2^D, so 2^D−1 wraps to 0.
- `halt` overrides `stall`, so a halt asserted during a stall still completes.
- Both jump enables asserted together: absolute wins.
- DONE:
  - `prog_ctr` holds the halting address.
  - `done` is 1 and `cycle_count` is frozen.
  - `start` reloads `start_addr`, clears the count and re-enters RUN.
- `start` is ignored in RUN.
- In IDLE and DONE the `stall`, `halt` and jump inputs are ignored.
- `cycle_count` increments on every RUN cycle, including stall cycles and the halt cycle. It saturates at all-ones and never wraps.
- Reset at any point, including mid-RUN:
  - state IDLE, `prog_ctr` = 0, `cycle_count` = 0;
  - `running` = 0, `done` = 0.

## Timing
- All outputs are registered.
- Reset values: `prog_ctr` 0, `running` 0, `done` 0, `cycle_count` 0.
- Start: `start` is sampled at edge t. From cycle t+1, `prog_ctr` = `start_addr` and `running` = 1.
- Control latency: control inputs presented in cycle t, qualified by the `mach_code` fetched at `prog_ctr`(t), take effect on `prog_ctr` at t+1. There are no delay slots.
- Halt: `halt` at cycle t gives `running` = 0 and `done` = 1 at t+1, with `prog_ctr` unchanged. The count includes cycle t.
- Control inputs must be stable before the rising edge. No handshake is required beyond same-cycle sampling.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum {IDLE, RUN, DONE};
  - defaults for D, OW and CW;
  - a helper function `sext_off` that sign-extends OW to D.
- One combinational sub-module, `pc_next_calc`, implements the priority mux and the modulo adders. The FSM, PC register and counter stay in `fetch_ctrl`.

## Test plan
- Reset, then `start` with `start_addr` = 0x010, no control for 4 cycles -> `prog_ctr` = 0x010, 0x011, 0x012, 0x013, 0x014; `cycle_count` = 4.
- In RUN at PC 0x020, `rel_offset` = 0xFC (−4) -> next PC 0x01C. At PC 0xFFF with no control -> next PC 0x000.
- Same cycle: `abs_jump_en` with `abs_target` = 0x100, `rel_jump_en` with offset 5, and `stall` -> PC holds. Next cycle with stall removed -> PC = 0x100.
- `halt` with `stall` at PC 0x033 -> next cycle `done` = 1, `running` = 0, PC 0x033. Further jumps are ignored and the count is frozen.
- From DONE, `start` with `start_addr` = 0x200 -> RUN at 0x200 and the count restarts at 0. Async `reset` mid-RUN -> immediately PC 0, count 0, IDLE.
- CW = 4 with no halt for 20 cycles -> `cycle_count` sticks at 15.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, default widths and helpers for the fetch sequencing stage.
package fetch_pkg;

    localparam int unsigned D_DEF   = 12;
    localparam int unsigned OW_DEF  = 8;
    localparam int unsigned CW_DEF  = 16;
    localparam int unsigned SEXT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    // Sign-extend the low ow bits of off to SEXT_W bits; callers truncate to D.
    function automatic logic [SEXT_W-1:0] sext_off(input logic [SEXT_W-1:0] off,
                                                   input int unsigned       ow);
        logic signed [SEXT_W-1:0] shifted;
        int unsigned              sh;
        sh      = SEXT_W - ow;
        shifted = off << sh;
        return shifted >>> sh;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC priority mux for the RUN state: halt/stall hold, abs jump, rel jump, increment.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned OW = OW_DEF
) (
    input  logic [D-1:0]  pc_i,
    input  logic          halt_i,
    input  logic          stall_i,
    input  logic          abs_jump_en_i,
    input  logic [D-1:0]  abs_target_i,
    input  logic          rel_jump_en_i,
    input  logic [OW-1:0] rel_offset_i,
    output logic [D-1:0]  pc_next_c
);

    logic [D-1:0] rel_ext;

    assign rel_ext = D'(sext_off(SEXT_W'(rel_offset_i), OW));

    always_comb begin
        pc_next_c = pc_i + D'(1);
        if (halt_i || stall_i) begin
            pc_next_c = pc_i;
        end else if (abs_jump_en_i) begin
            pc_next_c = abs_target_i;
        end else if (rel_jump_en_i) begin
            pc_next_c = pc_i + rel_ext;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter / fetch sequencer with IDLE-RUN-DONE lifecycle and a saturating
// RUN-cycle counter.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned D  = D_DEF,
    parameter int unsigned OW = OW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          halt,
    input  logic          abs_jump_en,
    input  logic [D-1:0]  abs_target,
    input  logic          rel_jump_en,
    input  logic [OW-1:0] rel_offset,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    fetch_state_e  state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          running_q, done_q;
    logic [D-1:0]  pc_next_c;

    pc_next_calc #(
        .D  (D),
        .OW (OW)
    ) u_pc_next (
        .pc_i          (pc_q),
        .halt_i        (halt),
        .stall_i       (stall),
        .abs_jump_en_i (abs_jump_en),
        .abs_target_i  (abs_target),
        .rel_jump_en_i (rel_jump_en),
        .rel_offset_i  (rel_offset),
        .pc_next_c     (pc_next_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start) begin
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pc_d = pc_next_c;
                // Counter saturates so long programs report "at least" rather than wrap.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (halt) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign prog_ctr    = pc_q;
    assign running     = running_q;
    assign done        = done_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default widths plus a CW=4 instance).
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] start_addr;
    logic        stall;
    logic        halt;
    logic        abs_jump_en;
    logic [11:0] abs_target;
    logic        rel_jump_en;
    logic [7:0]  rel_offset;

    logic [11:0] prog_ctr;
    logic        running;
    logic        done;
    logic [15:0] cycle_count;

    logic [11:0] s_prog_ctr;
    logic        s_running;
    logic        s_done;
    logic [3:0]  s_cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .halt        (halt),
        .abs_jump_en (abs_jump_en),
        .abs_target  (abs_target),
        .rel_jump_en (rel_jump_en),
        .rel_offset  (rel_offset),
        .prog_ctr    (prog_ctr),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    fetch_ctrl #(.CW(4)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .halt        (halt),
        .abs_jump_en (abs_jump_en),
        .abs_target  (abs_target),
        .rel_jump_en (rel_jump_en),
        .rel_offset  (rel_offset),
        .prog_ctr    (s_prog_ctr),
        .running     (s_running),
        .done        (s_done),
        .cycle_count (s_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        start       = 1'b0;
        stall       = 1'b0;
        halt        = 1'b0;
        abs_jump_en = 1'b0;
        rel_jump_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_ctl();
        start_addr = 12'h000;
        abs_target = 12'h000;
        rel_offset = 8'h00;
        tick();
        n_cmp++; if (prog_ctr !== 12'h000) begin n_err++; $display("FAIL reset_pc: got %h want 000", prog_ctr); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        reset = 1'b0;
        tick();
        n_cmp++; if (prog_ctr !== 12'h000 || running !== 1'b0) begin n_err++; $display("FAIL idle_hold: pc %h run %b want 000 0", prog_ctr, running); end
    endtask

    task automatic test_sequential();
        logic [11:0] exp_pc;
        start      = 1'b1;
        start_addr = 12'h010;
        tick();
        start = 1'b0;
        n_cmp++; if (prog_ctr !== 12'h010) begin n_err++; $display("FAIL start_pc: got %h want 010", prog_ctr); end
        n_cmp++; if (running !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL start_flags: run %b done %b want 1 0", running, done); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL start_count: got %0d want 0", cycle_count); end
        exp_pc = 12'h010;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = exp_pc + 12'h001;
            n_cmp++; if (prog_ctr !== exp_pc) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, prog_ctr, exp_pc); end
        end
        n_cmp++; if (cycle_count !== 16'd4) begin n_err++; $display("FAIL seq_count: got %0d want 4", cycle_count); end
    endtask

    task automatic test_jumps();
        // start is asserted alongside the jump and must be ignored in RUN
        start       = 1'b1;
        start_addr  = 12'h300;
        abs_jump_en = 1'b1;
        abs_target  = 12'h020;
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'h020) begin n_err++; $display("FAIL abs_jump: got %h want 020", prog_ctr); end
        rel_jump_en = 1'b1;
        rel_offset  = 8'hFC;
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'h01C) begin n_err++; $display("FAIL rel_back: got %h want 01c", prog_ctr); end
        abs_jump_en = 1'b1;
        abs_target  = 12'hFFF;
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'hFFF) begin n_err++; $display("FAIL abs_top: got %h want fff", prog_ctr); end
        tick();
        n_cmp++; if (prog_ctr !== 12'h000) begin n_err++; $display("FAIL pc_wrap: got %h want 000", prog_ctr); end
    endtask

    task automatic test_priority();
        abs_jump_en = 1'b1;
        abs_target  = 12'h100;
        rel_jump_en = 1'b1;
        rel_offset  = 8'h05;
        stall       = 1'b1;
        tick();
        n_cmp++; if (prog_ctr !== 12'h000) begin n_err++; $display("FAIL stall_hold: got %h want 000", prog_ctr); end
        stall = 1'b0;
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'h100) begin n_err++; $display("FAIL abs_over_rel: got %h want 100", prog_ctr); end
        n_cmp++; if (cycle_count !== 16'd10) begin n_err++; $display("FAIL stall_counted: got %0d want 10", cycle_count); end
    endtask

    task automatic test_halt();
        abs_jump_en = 1'b1;
        abs_target  = 12'h033;
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'h033) begin n_err++; $display("FAIL pre_halt_pc: got %h want 033", prog_ctr); end
        halt  = 1'b1;
        stall = 1'b1;
        tick();
        clear_ctl();
        n_cmp++; if (done !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL halt_flags: done %b run %b want 1 0", done, running); end
        n_cmp++; if (prog_ctr !== 12'h033) begin n_err++; $display("FAIL halt_pc: got %h want 033", prog_ctr); end
        n_cmp++; if (cycle_count !== 16'd12) begin n_err++; $display("FAIL halt_count: got %0d want 12", cycle_count); end
        abs_jump_en = 1'b1;
        abs_target  = 12'h055;
        rel_jump_en = 1'b1;
        rel_offset  = 8'h07;
        tick();
        tick();
        clear_ctl();
        n_cmp++; if (prog_ctr !== 12'h033 || done !== 1'b1) begin n_err++; $display("FAIL done_ignore: pc %h done %b want 033 1", prog_ctr, done); end
        n_cmp++; if (cycle_count !== 16'd12) begin n_err++; $display("FAIL done_frozen: got %0d want 12", cycle_count); end
    endtask

    task automatic test_restart_and_reset();
        start      = 1'b1;
        start_addr = 12'h200;
        tick();
        start = 1'b0;
        n_cmp++; if (prog_ctr !== 12'h200 || running !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL restart: pc %h run %b done %b want 200 1 0", prog_ctr, running, done); end
        n_cmp++; if (cycle_count !== 16'd0) begin n_err++; $display("FAIL restart_count: got %0d want 0", cycle_count); end
        tick();
        n_cmp++; if (prog_ctr !== 12'h201 || cycle_count !== 16'd1) begin n_err++; $display("FAIL restart_step: pc %h cnt %0d want 201 1", prog_ctr, cycle_count); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (prog_ctr !== 12'h000 || cycle_count !== 16'd0) begin n_err++; $display("FAIL async_reset: pc %h cnt %0d want 000 0", prog_ctr, cycle_count); end
        n_cmp++; if (running !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL async_flags: run %b done %b want 0 0", running, done); end
        #1;
        reset = 1'b0;
        tick();
        n_cmp++; if (running !== 1'b0 || prog_ctr !== 12'h000) begin n_err++; $display("FAIL post_reset_idle: run %b pc %h want 0 000", running, prog_ctr); end
    endtask

    task automatic test_saturate();
        start      = 1'b1;
        start_addr = 12'h000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (s_cycle_count !== 4'd15) begin n_err++; $display("FAIL sat_count: got %0d want 15", s_cycle_count); end
        n_cmp++; if (s_running !== 1'b1 || s_prog_ctr !== 12'h014) begin n_err++; $display("FAIL sat_run: run %b pc %h want 1 014", s_running, s_prog_ctr); end
        n_cmp++; if (cycle_count !== 16'd20) begin n_err++; $display("FAIL wide_count: got %0d want 20", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jumps();
        test_priority();
        test_halt();
        test_restart_and_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
